// File: rtl/pool1_pkg.sv
// ---------------------------------------------------------------------------
// pool1_pkg
// Shared constants and types for the pool-1 sequencer.
//   IN_W / OUT_W   : feature-map edge length before / after 2x2 pooling
//   IN_AW / OUT_AW : f2 / f3 buffer address widths
//   N_RD / N_WR    : reads and writes issued per pass
//   pool1_state_e  : sequencer FSM encoding
//   next_win_base  : top-left f2 address of the following 2x2 window
// ---------------------------------------------------------------------------
package pool1_pkg;

    localparam int unsigned IN_W   = 28;
    localparam int unsigned OUT_W  = 14;
    localparam int unsigned IN_AW  = 10;
    localparam int unsigned OUT_AW = 8;
    localparam int unsigned CNT_W  = 4;            // holds 0..OUT_W-1
    localparam int unsigned N_RD   = IN_W * IN_W;   // 784
    localparam int unsigned N_WR   = OUT_W * OUT_W; // 196

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } pool1_state_e;

    // Windows step two columns right; at the end of an output row the next
    // window starts two input rows down, i.e. IN_W + 2 past the last one.
    function automatic logic [IN_AW-1:0] next_win_base(
        input logic [IN_AW-1:0] base,
        input logic             row_end
    );
        logic [IN_AW-1:0] nxt;
        if (row_end) begin
            nxt = base + IN_AW'(IN_W + 32'd2);
        end else begin
            nxt = base + IN_AW'(32'd2);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pool1_addr_gen.sv
// ---------------------------------------------------------------------------
// pool1_addr_gen
// Walks the 28x28 f2 map in 2x2 windows (row-major windows, q = dy:dx inside
// a window) and produces the shared f2 read address with adders only.
//   clk, rst_n : clock, synchronous active-low reset
//   adv        : a read is issued this cycle; step to the next address
//   raddr      : current read address (0 whenever no pass is reading)
//   win_first  : current address is the first read of its window (q == 0)
//   win_last   : current address is the last read of its window (q == 3)
//   last_rd    : current address is the final read of the pass
// ---------------------------------------------------------------------------
module pool1_addr_gen
    import pool1_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [IN_AW-1:0] raddr,
    output logic             win_first,
    output logic             win_last,
    output logic             last_rd
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_W - 32'd1);

    logic [1:0]       q_r,      q_nx_s;
    logic [CNT_W-1:0] ocol_r,   ocol_nx_s;
    logic [CNT_W-1:0] orow_r,   orow_nx_s;
    logic [IN_AW-1:0] base_r,   base_nx_s;
    logic [IN_AW-1:0] raddr_r,  raddr_nx_s;
    logic             col_end_s;
    logic             last_rd_s;

    assign col_end_s = (ocol_r == LAST_IDX);
    assign last_rd_s = (q_r == 2'd3) && col_end_s && (orow_r == LAST_IDX);

    assign raddr     = raddr_r;
    assign win_first = (q_r == 2'd0);
    assign win_last  = (q_r == 2'd3);
    assign last_rd   = last_rd_s;

    // Next-address arithmetic: +1 across a pair, +IN_W-1 down to the second
    // row of the window, and a jump to the next window base after q == 3.
    always_comb begin
        q_nx_s     = q_r;
        ocol_nx_s  = ocol_r;
        orow_nx_s  = orow_r;
        base_nx_s  = base_r;
        raddr_nx_s = raddr_r;
        if (adv) begin
            q_nx_s = q_r + 2'd1;
            case (q_r)
                2'd0, 2'd2: raddr_nx_s = raddr_r + IN_AW'(32'd1);
                2'd1:       raddr_nx_s = raddr_r + IN_AW'(IN_W - 32'd1);
                2'd3: begin
                    if (last_rd_s) begin
                        // Wrap to zero so the address idles at 0 between passes.
                        ocol_nx_s  = '0;
                        orow_nx_s  = '0;
                        base_nx_s  = '0;
                        raddr_nx_s = '0;
                    end else begin
                        base_nx_s  = next_win_base(base_r, col_end_s);
                        raddr_nx_s = next_win_base(base_r, col_end_s);
                        if (col_end_s) begin
                            ocol_nx_s = '0;
                            orow_nx_s = orow_r + CNT_W'(32'd1);
                        end else begin
                            ocol_nx_s = ocol_r + CNT_W'(32'd1);
                        end
                    end
                end
                default: raddr_nx_s = raddr_r;
            endcase
        end else begin
            q_nx_s = q_r;
        end
    end

    // Counter and address registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r     <= 2'd0;
            ocol_r  <= '0;
            orow_r  <= '0;
            base_r  <= '0;
            raddr_r <= '0;
        end else begin
            q_r     <= q_nx_s;
            ocol_r  <= ocol_nx_s;
            orow_r  <= orow_nx_s;
            base_r  <= base_nx_s;
            raddr_r <= raddr_nx_s;
        end
    end

endmodule

// File: rtl/pool1_ctrl.sv
// ---------------------------------------------------------------------------
// pool1_ctrl
// Sequencer for the six-lane pool-1 datapath. One pass reads all 784 f2
// words in 2x2-window order, strobes pool1_clr on each window's first
// returned word and writes the 196 pooled results to f3.
//   clk, rst_n  : clock, synchronous active-low reset (aborts a pass)
//   pool1_start : start pulse, honoured only when idle
//   pool1_busy  : high from the first read cycle through the done cycle
//   pool1_done  : one-cycle pulse after the last f3 write
//   f2_ren      : shared f2 read enable; f2_raddr shared read address
//   pool1_clr   : window-start strobe, aligned with returned read data
//   f3_wen      : shared f3 write enable; f3_waddr shared write address
// Parameter RD_LAT (1..3): f2 buffer read latency in cycles.
// ---------------------------------------------------------------------------
module pool1_ctrl
    import pool1_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pool1_start,
    output logic              pool1_busy,
    output logic              pool1_done,
    output logic              f2_ren,
    output logic [IN_AW-1:0]  f2_raddr,
    output logic              pool1_clr,
    output logic              f3_wen,
    output logic [OUT_AW-1:0] f3_waddr
);

    localparam logic [OUT_AW-1:0] LAST_WADDR = OUT_AW'(N_WR - 32'd1);

    pool1_state_e      state_r, state_nx_s;
    logic              ren_r, busy_r, done_r;
    logic [RD_LAT-1:0] clr_sr_r;
    logic [RD_LAT:0]   wen_sr_r;
    logic [OUT_AW-1:0] wr_cnt_r, waddr_r;
    logic              win_first_s, win_last_s, last_rd_s;
    logic              first_s, last_s, wr_last_s;

    pool1_addr_gen u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (ren_r),
        .raddr     (f2_raddr),
        .win_first (win_first_s),
        .win_last  (win_last_s),
        .last_rd   (last_rd_s)
    );

    // Issue-side window flags, only meaningful while a read is going out.
    assign first_s   = ren_r & win_first_s;
    assign last_s    = ren_r & win_last_s;
    assign wr_last_s = wen_sr_r[RD_LAT] & (waddr_r == LAST_WADDR);

    assign pool1_busy = busy_r;
    assign pool1_done = done_r;
    assign f2_ren     = ren_r;
    assign pool1_clr  = clr_sr_r[RD_LAT-1];
    assign f3_wen     = wen_sr_r[RD_LAT];
    assign f3_waddr   = waddr_r;

    // Next-state logic; pool1_start is only looked at in IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pool1_start) begin
                    state_nx_s = S_READ;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_READ: begin
                if (last_rd_s) begin
                    state_nx_s = S_DRAIN;
                end else begin
                    state_nx_s = S_READ;
                end
            end
            S_DRAIN: begin
                if (wr_last_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_DRAIN;
                end
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State register with status strobes registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            ren_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ren_r   <= (state_nx_s == S_READ);
            busy_r  <= (state_nx_s != S_IDLE);
            done_r  <= (state_nx_s == S_DONE);
        end
    end

    // Delay lines: clr lands RD_LAT cycles after a window's first read, wen
    // one cycle after the window's last word has been folded into d_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_sr_r <= '0;
            wen_sr_r <= '0;
        end else begin
            clr_sr_r[0] <= first_s;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                clr_sr_r[i] <= clr_sr_r[i-1];
            end
            wen_sr_r[0] <= last_s;
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                wen_sr_r[i] <= wen_sr_r[i-1];
            end
        end
    end

    // Write address: loaded from the 0..195 counter in the same edge that
    // raises f3_wen, and forced to 0 otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_r <= '0;
            waddr_r  <= '0;
        end else if (wen_sr_r[RD_LAT-1]) begin
            waddr_r <= wr_cnt_r;
            if (wr_cnt_r == LAST_WADDR) begin
                wr_cnt_r <= '0;
            end else begin
                wr_cnt_r <= wr_cnt_r + OUT_AW'(32'd1);
            end
        end else begin
            waddr_r <= '0;
        end
    end

endmodule

// File: tb/tb_pool1_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pool1_ctrl
// Self-checking bench for pool1_ctrl. Two instances: RD_LAT=1 (with
// behavioural f2 buffers, six pool units and f3 buffers around it) and
// RD_LAT=3. Expected per-cycle strobes and addresses come from closed-form
// arithmetic on the cycle number; pooled results from max over each window.
// ---------------------------------------------------------------------------
module tb_pool1_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start1, busy1, done1, ren1, clr1, wen1;
    logic [9:0] raddr1;
    logic [7:0] waddr1;
    logic       start3, busy3, done3, ren3, clr3, wen3;
    logic [9:0] raddr3;
    logic [7:0] waddr3;

    int tests = 0;
    int fails = 0;

    // Environment around the RD_LAT=1 instance
    logic [15:0] f2m [0:5][0:783];
    logic [15:0] f3m [0:5][0:195];
    logic [15:0] rdata1 [0:5];
    logic [15:0] pool_q [0:5];
    logic        f3_clr_req;

    // Trace of the most recent RD_LAT=1 pass, indexed by cycle
    logic [9:0] tr_raddr [0:1023];
    logic       tr_clr   [0:1023];
    logic       tr_wen   [0:1023];
    logic [7:0] tr_waddr [0:1023];
    logic       tr_done  [0:1023];
    logic       tr_busy  [0:1023];

    pool1_ctrl #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pool1_start(start1), .pool1_busy(busy1),
        .pool1_done(done1), .f2_ren(ren1), .f2_raddr(raddr1), .pool1_clr(clr1),
        .f3_wen(wen1), .f3_waddr(waddr1)
    );

    pool1_ctrl #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .pool1_start(start3), .pool1_busy(busy3),
        .pool1_done(done3), .f2_ren(ren3), .f2_raddr(raddr3), .pool1_clr(clr3),
        .f3_wen(wen3), .f3_waddr(waddr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // f2 buffers (1-cycle read), pool units (clr loads, else running max), f3 buffers
    always @(posedge clk) begin
        for (int n = 0; n < 6; n++) begin
            if (ren1) rdata1[n] <= f2m[n][raddr1];
            if (clr1) pool_q[n] <= rdata1[n];
            else if (rdata1[n] > pool_q[n]) pool_q[n] <= rdata1[n];
            if (f3_clr_req) begin
                for (int a = 0; a < 196; a++) f3m[n][a] <= 16'hFFFF;
            end else if (wen1) begin
                f3m[n][waddr1] <= pool_q[n];
            end
        end
    end

    // ---------------- reference model (cycle c, start sampled at edge 0) ----
    function automatic logic exp_ren(int c);
        return (c >= 1 && c <= 784);
    endfunction

    function automatic logic [9:0] exp_raddr(int c);
        int i, k, q;
        if (c < 1 || c > 784) return 10'd0;
        i = c - 1; k = i / 4; q = i % 4;
        return 10'((2 * (k / 14) + q / 2) * 28 + 2 * (k % 14) + q % 2);
    endfunction

    function automatic logic exp_clr(int c, int lat);
        int i = c - 1 - lat;
        return (i >= 0 && i < 784 && (i % 4) == 0);
    endfunction

    function automatic logic exp_wen(int c, int lat);
        int i = c - 5 - lat;
        return (i >= 0 && (i % 4) == 0 && (i / 4) < 196);
    endfunction

    function automatic logic [7:0] exp_waddr(int c, int lat);
        if (!exp_wen(c, lat)) return 8'd0;
        return 8'((c - 5 - lat) / 4);
    endfunction

    function automatic logic exp_done(int c, int lat);
        return (c == 786 + lat);
    endfunction

    function automatic logic exp_busy(int c, int lat);
        return (c >= 1 && c <= 786 + lat);
    endfunction

    // ---------------- scenarios ---------------------------------------------
    task automatic idle_gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_f3();
        f3_clr_req = 1'b1;
        @(negedge clk);
        f3_clr_req = 1'b0;
    endtask

    // One RD_LAT=1 pass: start, then every cycle through 788 against the model.
    // Returns on the negedge of cycle 788 so a back-to-back start can follow.
    task automatic pass_trace1(input string tag);
        int wens = 0;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int c = 1; c <= 788; c++) begin
            @(negedge clk);
            tr_raddr[c] = raddr1; tr_clr[c] = clr1; tr_wen[c] = wen1;
            tr_waddr[c] = waddr1; tr_done[c] = done1; tr_busy[c] = busy1;
            if (wen1) wens++;
            tests++; if (ren1 !== exp_ren(c)) begin fails++; $display("FAIL %s ren c=%0d got %b exp %b", tag, c, ren1, exp_ren(c)); end
            tests++; if (raddr1 !== exp_raddr(c)) begin fails++; $display("FAIL %s raddr c=%0d got %0d exp %0d", tag, c, raddr1, exp_raddr(c)); end
            tests++; if (clr1 !== exp_clr(c, 1)) begin fails++; $display("FAIL %s clr c=%0d got %b exp %b", tag, c, clr1, exp_clr(c, 1)); end
            tests++; if (wen1 !== exp_wen(c, 1)) begin fails++; $display("FAIL %s wen c=%0d got %b exp %b", tag, c, wen1, exp_wen(c, 1)); end
            tests++; if (waddr1 !== exp_waddr(c, 1)) begin fails++; $display("FAIL %s waddr c=%0d got %0d exp %0d", tag, c, waddr1, exp_waddr(c, 1)); end
            tests++; if (done1 !== exp_done(c, 1)) begin fails++; $display("FAIL %s done c=%0d got %b exp %b", tag, c, done1, exp_done(c, 1)); end
            tests++; if (busy1 !== exp_busy(c, 1)) begin fails++; $display("FAIL %s busy c=%0d got %b exp %b", tag, c, busy1, exp_busy(c, 1)); end
        end
        tests++; if (wens != 196) begin fails++; $display("FAIL %s wen_count got %0d exp 196", tag, wens); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; f3_clr_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if ({busy1, done1, ren1, clr1, wen1} !== 5'b0) begin fails++; $display("FAIL reset strobes1 got %b exp 00000", {busy1, done1, ren1, clr1, wen1}); end
        tests++; if ({raddr1, waddr1} !== 18'd0) begin fails++; $display("FAIL reset addr1 got %0d/%0d exp 0/0", raddr1, waddr1); end
        tests++; if ({busy3, done3, ren3, clr3, wen3} !== 5'b0) begin fails++; $display("FAIL reset strobes3 got %b exp 00000", {busy3, done3, ren3, clr3, wen3}); end
        tests++; if ({raddr3, waddr3} !== 18'd0) begin fails++; $display("FAIL reset addr3 got %0d/%0d exp 0/0", raddr3, waddr3); end
        rst_n = 1'b1;
        idle_gap(3);
        tests++; if ({busy1, ren1, busy3, ren3} !== 4'b0) begin fails++; $display("FAIL idle_after_reset got %b exp 0000", {busy1, ren1, busy3, ren3}); end
    endtask

    task automatic test_single_pass();
        int sc [20];
        int sa [20];
        sc = '{1, 2, 3, 4, 5, 6, 7, 8, 53, 54, 55, 56, 57, 58, 59, 60, 781, 782, 783, 784};
        sa = '{0, 1, 28, 29, 2, 3, 30, 31, 26, 27, 54, 55, 56, 57, 84, 85, 754, 755, 782, 783};
        for (int n = 0; n < 6; n++)
            for (int a = 0; a < 784; a++) f2m[n][a] = 16'(a + n);
        clear_f3();
        pass_trace1("single");
        for (int i = 0; i < 20; i++) begin
            tests++; if (tr_raddr[sc[i]] !== 10'(sa[i])) begin fails++; $display("FAIL plan_raddr c=%0d got %0d exp %0d", sc[i], tr_raddr[sc[i]], sa[i]); end
        end
        tests++; if ({tr_clr[2], tr_clr[3], tr_clr[6]} !== 3'b101) begin fails++; $display("FAIL plan_clr got %b exp 101", {tr_clr[2], tr_clr[3], tr_clr[6]}); end
        tests++; if (tr_wen[6] !== 1'b1 || tr_waddr[6] !== 8'd0) begin fails++; $display("FAIL plan_first_wen got %b/%0d exp 1/0", tr_wen[6], tr_waddr[6]); end
        tests++; if (tr_wen[786] !== 1'b1 || tr_waddr[786] !== 8'd195) begin fails++; $display("FAIL plan_last_wen got %b/%0d exp 1/195", tr_wen[786], tr_waddr[786]); end
        tests++; if ({tr_done[786], tr_done[787], tr_busy[787], tr_busy[788]} !== 4'b0110) begin fails++; $display("FAIL plan_end got %b exp 0110", {tr_done[786], tr_done[787], tr_busy[787], tr_busy[788]}); end
        idle_gap(2);
        for (int n = 0; n < 6; n++)
            for (int k = 0; k < 196; k++) begin
                tests++;
                if (f3m[n][k] !== 16'((2 * (k / 14) + 1) * 28 + 2 * (k % 14) + 1 + n)) begin
                    fails++; $display("FAIL f3_ramp lane=%0d k=%0d got %0d exp %0d", n, k, f3m[n][k], (2 * (k / 14) + 1) * 28 + 2 * (k % 14) + 1 + n);
                end
            end
    endtask

    task automatic test_random_data();
        logic [15:0] m;
        int base;
        for (int n = 0; n < 6; n++)
            for (int a = 0; a < 784; a++) f2m[n][a] = 16'($urandom_range(0, 60000));
        clear_f3();
        idle_gap($urandom_range(1, 20));
        pass_trace1("random");
        idle_gap(2);
        for (int n = 0; n < 6; n++)
            for (int k = 0; k < 196; k++) begin
                base = 2 * (k / 14) * 28 + 2 * (k % 14);
                m = f2m[n][base];
                if (f2m[n][base + 1] > m)  m = f2m[n][base + 1];
                if (f2m[n][base + 28] > m) m = f2m[n][base + 28];
                if (f2m[n][base + 29] > m) m = f2m[n][base + 29];
                tests++; if (f3m[n][k] !== m) begin fails++; $display("FAIL f3_max lane=%0d k=%0d got %0d exp %0d", n, k, f3m[n][k], m); end
            end
    endtask

    task automatic test_start_ignored_rdlat3();
        int wens = 0;
        idle_gap($urandom_range(1, 20));
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        for (int c = 1; c <= 809; c++) begin
            @(negedge clk);
            if (wen3) wens++;
            tests++; if (ren3 !== exp_ren(c)) begin fails++; $display("FAIL lat3 ren c=%0d got %b exp %b", c, ren3, exp_ren(c)); end
            tests++; if (raddr3 !== exp_raddr(c)) begin fails++; $display("FAIL lat3 raddr c=%0d got %0d exp %0d", c, raddr3, exp_raddr(c)); end
            tests++; if (clr3 !== exp_clr(c, 3)) begin fails++; $display("FAIL lat3 clr c=%0d got %b exp %b", c, clr3, exp_clr(c, 3)); end
            tests++; if (wen3 !== exp_wen(c, 3)) begin fails++; $display("FAIL lat3 wen c=%0d got %b exp %b", c, wen3, exp_wen(c, 3)); end
            tests++; if (waddr3 !== exp_waddr(c, 3)) begin fails++; $display("FAIL lat3 waddr c=%0d got %0d exp %0d", c, waddr3, exp_waddr(c, 3)); end
            tests++; if (done3 !== exp_done(c, 3)) begin fails++; $display("FAIL lat3 done c=%0d got %b exp %b", c, done3, exp_done(c, 3)); end
            tests++; if (busy3 !== exp_busy(c, 3)) begin fails++; $display("FAIL lat3 busy c=%0d got %b exp %b", c, busy3, exp_busy(c, 3)); end
            if (c == 4 || c == 8) begin
                tests++; if (clr3 !== 1'b1) begin fails++; $display("FAIL lat3 plan_clr c=%0d got %b exp 1", c, clr3); end
            end
            if (c == 789) begin
                tests++; if (done3 !== 1'b1) begin fails++; $display("FAIL lat3 plan_done c=789 got %b exp 1", done3); end
            end
            // Start pulse in the middle of the pass, sampled at edge 100
            start3 = (c == 100);
        end
        tests++; if (wens != 196) begin fails++; $display("FAIL lat3 wen_count got %0d exp 196", wens); end
    endtask

    task automatic test_reset_mid_pass();
        int dones = 0;
        idle_gap($urandom_range(1, 20));
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            tests++; if (raddr1 !== exp_raddr(c)) begin fails++; $display("FAIL pre_rst raddr c=%0d got %0d exp %0d", c, raddr1, exp_raddr(c)); end
        end
        rst_n = 1'b0;
        for (int c = 301; c <= 320; c++) begin
            @(negedge clk);
            if (done1) dones++;
            tests++; if ({busy1, done1, ren1, clr1, wen1} !== 5'b0) begin fails++; $display("FAIL mid_rst strobes c=%0d got %b exp 00000", c, {busy1, done1, ren1, clr1, wen1}); end
            tests++; if ({raddr1, waddr1} !== 18'd0) begin fails++; $display("FAIL mid_rst addr c=%0d got %0d/%0d exp 0/0", c, raddr1, waddr1); end
            if (c == 305) rst_n = 1'b1;
        end
        tests++; if (dones != 0) begin fails++; $display("FAIL mid_rst done_count got %0d exp 0", dones); end
        pass_trace1("after_rst");
    endtask

    task automatic test_back_to_back();
        idle_gap($urandom_range(1, 20));
        pass_trace1("b2b_first");
        pass_trace1("b2b_second");
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_random_data();
        test_start_ignored_rdlat3();
        test_reset_mid_pass();
        test_back_to_back();
        idle_gap(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "time limit exceeded");
    end

endmodule
